// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: round-robin scan of NUM_SLOTS shadowed 5-bit values onto one shared
// display datapath. Define DISPLAY_SCAN_BLANK_EN to insert dark blanking cycles between slots.
module display_scan_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SLOTS-1:0]   load,
  input  logic [5*NUM_SLOTS-1:0] in_vals,
  input  logic [NUM_SLOTS-1:0]   enable,
  output logic [4:0]             disp_in,
  output logic [NUM_SLOTS-1:0]   disp_sel,
  output logic                   frame_done
);
  localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NUM_SLOTS);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

`ifdef DISPLAY_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic {IDLE, SCAN} state_t;
`endif

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4:0]                disp_in_q, disp_in_d;
  logic [NUM_SLOTS-1:0]      disp_sel_q, disp_sel_d;
  logic                      frame_done_q, frame_done_d;
  logic [NUM_SLOTS-1:0][4:0] shadow_q;

  logic [IW-1:0] nxt, first, enter_idx;
  logic          enter, go_idle;

  // First enabled index strictly after cur, wrapping; returns cur if only cur is enabled.
  function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] cur,
                                               input logic [NUM_SLOTS-1:0] en);
    logic [IW-1:0] r;
    logic          hit;
    int            j;
    r   = cur;
    hit = 1'b0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      j = (int'(cur) + k) % NUM_SLOTS;
      if (!hit && en[j]) begin
        r   = IW'(j);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (load[i]) shadow_q[i] <= in_vals[5*i +: 5];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_in_d    = disp_in_q;
    disp_sel_d   = disp_sel_q;
    frame_done_d = 1'b0;
    enter        = 1'b0;
    go_idle      = 1'b0;
    nxt          = next_slot(idx_q, enable);
    first        = next_slot(IW'(NUM_SLOTS - 1), enable);
    enter_idx    = nxt;
    case (state_q)
      IDLE: begin
        if (|enable) begin
          enter     = 1'b1;
          enter_idx = first;
        end
      end
      SCAN: begin
        if (enable == '0) begin
          go_idle = 1'b1;
        end else if (!enable[idx_q] || cnt_q == DWELL_LAST) begin
`ifdef DISPLAY_SCAN_BLANK_EN
          state_d    = BLANK;
          cnt_d      = '0;
          disp_sel_d = '0;
`else
          enter        = 1'b1;
          frame_done_d = (nxt <= idx_q);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef DISPLAY_SCAN_BLANK_EN
      BLANK: begin
        // disp_in keeps the previous slot's value while dark
        if (enable == '0) begin
          go_idle = 1'b1;
        end else if (cnt_q == BLANK_LAST) begin
          enter        = 1'b1;
          frame_done_d = (nxt <= idx_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Slot entry is the only point disp_in reloads, so shadow loads never tear a dwell.
    if (enter) begin
      state_d    = SCAN;
      idx_d      = enter_idx;
      cnt_d      = '0;
      disp_sel_d = NUM_SLOTS'(1) << enter_idx;
      disp_in_d  = shadow_q[enter_idx];
    end
    if (go_idle) begin
      state_d    = IDLE;
      cnt_d      = '0;
      disp_sel_d = '0;
      disp_in_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_in_q    <= '0;
      disp_sel_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_in_q    <= disp_in_d;
      disp_sel_q   <= disp_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp_in    = disp_in_q;
  assign disp_sel   = disp_sel_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus randomized traffic against a
// slot-list reference model (honours DISPLAY_SCAN_BLANK_EN when defined).
module tb_display_scan_ctrl;
  localparam int NS = 4, DW = 4, BC = 2;
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif
  localparam int P     = DW + (BLANK_ON ? BC : 0);
  localparam int FRAME = NS * P;

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  load = '0, enable = '0;
  logic [19:0] in_vals = '0;
  logic [4:0]  disp_in;
  logic [3:0]  disp_sel;
  logic        frame_done;
  int          n_cmp = 0, n_err = 0;

  display_scan_ctrl #(.NUM_SLOTS(NS), .DWELL(DW), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .in_vals(in_vals), .enable(enable),
    .disp_in(disp_in), .disp_sel(disp_sel), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Reference model: mode 0 dark, 1 showing m_slot, 2 blanking; m_left = cycles left in phase.
  int         m_sh [NS];
  int         m_mode, m_slot, m_left;
  logic [4:0] m_din;
  logic [3:0] m_sel;
  logic       m_fd;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_sh[i] = 0;
    m_mode = 0; m_slot = 0; m_left = 0; m_din = '0; m_sel = '0; m_fd = 1'b0;
  endtask

  // Smallest enabled index above cur, else smallest enabled overall.
  function automatic int next_en(input int cur, input logic [3:0] en);
    int lo, hi;
    lo = -1; hi = -1;
    for (int j = 0; j < NS; j++)
      if (en[j]) begin
        if (lo < 0) lo = j;
        if (j > cur && hi < 0) hi = j;
      end
    return (hi >= 0) ? hi : lo;
  endfunction

  task automatic model_edge();
    int s;
    s = -1;
    m_fd = 1'b0;
    if (m_mode == 0) begin
      if (enable != 0) s = next_en(-1, enable);
    end else if (enable == 0) begin
      m_mode = 0; m_sel = '0; m_din = '0;
    end else if (m_mode == 1) begin
      if (!enable[m_slot] || m_left == 1) begin
        if (BLANK_ON) begin
          m_mode = 2; m_left = BC; m_sel = '0;
        end else begin
          s = next_en(m_slot, enable); m_fd = (s <= m_slot);
        end
      end else m_left--;
    end else begin
      if (m_left == 1) begin
        s = next_en(m_slot, enable); m_fd = (s <= m_slot);
      end else m_left--;
    end
    if (s >= 0) begin
      m_mode = 1; m_slot = s; m_left = DW; m_sel = 4'(1 << s); m_din = 5'(m_sh[s]);
    end
    for (int i = 0; i < NS; i++) if (load[i]) m_sh[i] = int'(in_vals[5*i +: 5]);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic wait_entry(input logic [3:0] tgt, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      prev = disp_sel;
      cyc();
      if (disp_sel == tgt && prev != tgt) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; load = '0; enable = '0; in_vals = '0;
    model_reset();
    #1;
    n_cmp++;
    if ({disp_sel, disp_in, frame_done} !== 10'b0) begin
      n_err++; $display("FAIL reset_init: got sel=%b din=%0d fd=%b, want 0", disp_sel, disp_in, frame_done);
    end
    cyc(); cyc();
    rst = 1'b0;
    in_vals = {4{5'd7}}; load = 4'hf; cyc(); load = '0;
    enable = 4'hf;
    wait_entry(4'b0100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_wait: timeout got sel=%b want 0100", disp_sel); end
    cyc();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({disp_sel, disp_in, frame_done} !== 10'b0) begin
      n_err++; $display("FAIL reset_async: got sel=%b din=%0d fd=%b, want 0", disp_sel, disp_in, frame_done);
    end
    model_reset();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      cyc();
      n_cmp++;
      if (disp_in !== 5'd0 || disp_sel !== m_sel) begin
        n_err++; $display("FAIL reset_shadow: got sel=%b din=%0d, want sel=%b din=0", disp_sel, disp_in, m_sel);
      end
    end
  endtask

  task automatic test_scan_order();
    int         xs [5] = '{1, 2, 4, 8, 1};
    int         xd [5] = '{5, 17, 31, 0, 5};
    int         xf [5] = '{0, 0, 0, 0, 1};
    logic [3:0] es [5];
    logic [4:0] ed [5];
    logic       ef [5];
    int         ec [5];
    int         ne;
    logic [3:0] prev;
    enable = '0; cyc(); cyc();
    in_vals = {5'd0, 5'd31, 5'd17, 5'd5}; load = 4'hf; cyc(); load = '0;
    enable = 4'hf;
    ne = 0;
    for (int i = 0; i < 60 && ne < 5; i++) begin
      prev = disp_sel;
      cyc();
      n_cmp++;
      if (disp_sel !== m_sel || disp_in !== m_din || frame_done !== m_fd) begin
        n_err++; $display("FAIL scan_model: got %b/%0d/%b want %b/%0d/%b", disp_sel, disp_in, frame_done, m_sel, m_din, m_fd);
      end
      if (disp_sel != 0 && disp_sel != prev) begin
        es[ne] = disp_sel; ed[ne] = disp_in; ef[ne] = frame_done; ec[ne] = i; ne++;
      end
    end
    n_cmp++;
    if (ne != 5) begin n_err++; $display("FAIL scan_entries: got %0d entries want 5", ne); end
    for (int k = 0; k < ne; k++) begin
      n_cmp++;
      if (es[k] !== 4'(xs[k]) || ed[k] !== 5'(xd[k]) || ef[k] !== xf[k][0]) begin
        n_err++; $display("FAIL scan_entry%0d: got sel=%b din=%0d fd=%b want sel=%b din=%0d fd=%0d",
                          k, es[k], ed[k], ef[k], 4'(xs[k]), xd[k], xf[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (ec[k] - ec[k-1] != P) begin
          n_err++; $display("FAIL scan_spacing: got %0d cycles want %0d", ec[k] - ec[k-1], P);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    wait_entry(4'b0010, ok);
    n_cmp++;
    if (!ok || disp_in !== 5'd17) begin
      n_err++; $display("FAIL tear_entry: got ok=%b din=%0d want 1/17", ok, disp_in);
    end
    in_vals[9:5] = 5'd9; load = 4'b0010; cyc(); load = '0;
    for (int i = 0; i < DW-1; i++) begin
      n_cmp++;
      if (disp_sel !== 4'b0010 || disp_in !== 5'd17) begin
        n_err++; $display("FAIL tear_hold: got sel=%b din=%0d want 0010/17", disp_sel, disp_in);
      end
      cyc();
    end
    wait_entry(4'b0010, ok);
    n_cmp++;
    if (!ok || disp_in !== 5'd9) begin
      n_err++; $display("FAIL tear_next: got ok=%b din=%0d want 1/9", ok, disp_in);
    end
  endtask

  task automatic test_subset();
    logic [3:0] prev;
    logic       xfd;
    int         n0;
    enable = 4'b0101;
    n0 = 0;
    for (int i = 0; i < 40; i++) begin
      prev = disp_sel;
      cyc();
      xfd = (disp_sel != prev && disp_sel == 4'b0001);
      if (xfd) n0++;
      n_cmp++;
      if (disp_sel[1] !== 1'b0 || disp_sel[3] !== 1'b0 || frame_done !== xfd || disp_in !== m_din || disp_sel !== m_sel) begin
        n_err++; $display("FAIL subset: got sel=%b fd=%b din=%0d want sel=%b fd=%b din=%0d",
                          disp_sel, frame_done, disp_in, m_sel, xfd, m_din);
      end
    end
    n_cmp++;
    if (n0 < 3) begin n_err++; $display("FAIL subset_visits: got %0d slot0 entries want >=3", n0); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n;
    enable = 4'hf;
    wait_entry(4'b0100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL drop_wait: timeout got sel=%b want 0100", disp_sel); end
    cyc();
    enable = 4'b1011;
    cyc();
    n_cmp++;
    if (disp_sel !== (BLANK_ON ? 4'b0000 : 4'b1000)) begin
      n_err++; $display("FAIL drop_advance: got sel=%b want %b", disp_sel, BLANK_ON ? 4'b0000 : 4'b1000);
    end
    for (int i = 0; i < (BLANK_ON ? BC : 0); i++) cyc();
    n_cmp++;
    if (disp_sel !== 4'b1000 || disp_in !== m_din) begin
      n_err++; $display("FAIL drop_enter: got sel=%b din=%0d want 1000/%0d", disp_sel, disp_in, m_din);
    end
    n = 1;
    while (n < 20) begin
      cyc();
      if (disp_sel != 4'b1000) break;
      n++;
    end
    n_cmp++;
    if (n != DW) begin n_err++; $display("FAIL drop_dwell: got %0d cycles want %0d", n, DW); end
    enable = '0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if (disp_sel !== 4'b0 || disp_in !== 5'd0 || frame_done !== 1'b0) begin
        n_err++; $display("FAIL idle: got sel=%b din=%0d fd=%b want 0", disp_sel, disp_in, frame_done);
      end
    end
  endtask

  task automatic test_single_slot();
    int nfd;
    enable = '0; cyc();
    enable = 4'b0010;
    nfd = 0;
    for (int i = 1; i <= 3*P + 1; i++) begin
      cyc();
      if (frame_done) nfd++;
      n_cmp++;
      if (disp_sel !== m_sel || disp_in !== m_din || frame_done !== m_fd) begin
        n_err++; $display("FAIL single_model: got %b/%0d/%b want %b/%0d/%b", disp_sel, disp_in, frame_done, m_sel, m_din, m_fd);
      end
      if (i == 1) begin in_vals[9:5] = 5'd22; load = 4'b0010; end
      else load = '0;
    end
    n_cmp++;
    if (nfd != 3) begin n_err++; $display("FAIL single_fd: got %0d pulses want 3", nfd); end
    n_cmp++;
    if (disp_sel !== 4'b0010 || disp_in !== 5'd22) begin
      n_err++; $display("FAIL single_refresh: got sel=%b din=%0d want 0010/22", disp_sel, disp_in);
    end
  endtask

  task automatic test_frame_period();
    int  n;
    bit  seen;
    enable = 4'hf;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin cyc(); seen = frame_done; end
    n = 0;
    if (seen) begin
      for (int i = 0; i < 100; i++) begin
        cyc(); n++;
        if (frame_done) break;
      end
    end
    n_cmp++;
    if (n != FRAME) begin n_err++; $display("FAIL frame_period: got %0d cycles want %0d", n, FRAME); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      load    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      in_vals = 20'($urandom);
      if ($urandom_range(0, 15) == 0) enable = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({disp_sel, disp_in, frame_done} !== 10'b0) begin
          n_err++; $display("FAIL random_reset: got sel=%b din=%0d fd=%b want 0", disp_sel, disp_in, frame_done);
        end
        model_reset();
        cyc();
        rst = 1'b0;
      end
      cyc();
      n_cmp++;
      if (disp_sel !== m_sel || disp_in !== m_din || frame_done !== m_fd || $countones(disp_sel) > 1) begin
        n_err++; $display("FAIL random@%0d: got %b/%0d/%b want %b/%0d/%b", i, disp_sel, disp_in, frame_done, m_sel, m_din, m_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_subset();
    test_enable_drop();
    test_single_slot();
    test_frame_period();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
